fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and stall counter width.
package cpu_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams words from a synchronous-read imem to the decoder.
// Optional stall cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int INST_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_SIZE-1:0]   imem_addr,
  input  logic [INST_SIZE-1:0]   imem_data,
  output logic [INST_SIZE-1:0]   inst,
  output logic [ADDR_SIZE-1:0]   inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [ADDR_SIZE-1:0]   redirect_addr,
  input  logic                   halt_req,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [INST_SIZE-1:0]   inst_q, inst_d;
  logic [ADDR_SIZE-1:0]   inst_pc_q, inst_pc_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   halted_q, halted_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [INST_SIZE-1:0]   skid_data_q, skid_data_d;
  logic                   stalled;

  assign stalled = inst_valid_q & ~inst_ready;

  // The memory keeps reading the held fetch_pc during a stall, so the word for
  // fetch_pc-1 is only on imem_data in the first stall cycle; the skid keeps it.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    unique case (state_q)
      FLUSH: begin
        inst_valid_d = 1'b0;
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end else begin
          fetch_pc_d = fetch_pc_q + ADDR_SIZE'(1);
          state_d    = RUN;
        end
      end
      RUN: begin
        if (inst_valid_q && halt_req) begin
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = HALT;
        end else if (redirect) begin
          inst_valid_d = 1'b0;
          fetch_pc_d   = redirect_addr;
          skid_valid_d = 1'b0;
          state_d      = FLUSH;
        end else if (stalled) begin
          if (!skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = imem_data;
          end
        end else begin
          inst_d       = skid_valid_q ? skid_data_q : imem_data;
          inst_pc_d    = fetch_pc_q - ADDR_SIZE'(1);
          inst_valid_d = 1'b1;
          fetch_pc_d   = fetch_pc_q + ADDR_SIZE'(1);
          skid_valid_d = 1'b0;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FLUSH;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLUSH;
      fetch_pc_q   <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != HALT && stalled && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

  assign imem_addr  = fetch_pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a transaction-level model of the instruction stream.
module tb_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          halt_req;
  logic          halted;
  logic [15:0]   stall_count;

  fetch_unit #(.ADDR_SIZE(AW), .INST_SIZE(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt_req      (halt_req),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word k holds 16'h1000 + k.
  logic [IW-1:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = IW'(16'h1000 + k);
  always @(posedge clk) imem_data <= mem[imem_addr];

  // Reference model: the stream of instructions the decoder should see.
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_inst;
  logic [AW-1:0] m_next;
  int            m_bubble;
  logic          m_halted;
  int            m_stalls;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic rdy, input logic rd,
                            input logic [AW-1:0] ra, input logic hq);
    if (r) begin
      m_valid = 1'b0; m_pc = '0; m_inst = '0; m_next = '0;
      m_bubble = 2; m_halted = 1'b0; m_stalls = 0;
    end else if (!m_halted) begin
      if (m_valid && !rdy && m_stalls < 65535) m_stalls++;
      if (m_valid && hq) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end else if (rd) begin
        m_valid  = 1'b0;
        m_next   = ra;
        m_bubble = 2;
      end else if (!(m_valid && !rdy)) begin
        if (m_bubble > 0) m_bubble--;
        if (m_bubble == 0) begin
          m_valid = 1'b1;
          m_pc    = m_next;
          m_inst  = mem[m_next];
          m_next  = m_next + 8'd1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_stalls;
    // The fetch address runs one word ahead of the next instruction once the memory is primed.
    exp_addr = m_next + ((m_bubble == 2) ? 8'd0 : 8'd1);
`ifdef FETCH_STALL_CNT_EN
    exp_stalls = 16'(m_stalls);
`else
    exp_stalls = 16'd0;
`endif
    check("inst_valid",  32'(inst_valid),  32'(m_valid));
    check("inst_pc",     32'(inst_pc),     32'(m_pc));
    check("inst",        32'(inst),        32'(m_inst));
    check("imem_addr",   32'(imem_addr),   32'(exp_addr));
    check("halted",      32'(halted),      32'(m_halted));
    check("stall_count", 32'(stall_count), 32'(exp_stalls));
  endtask

  // One clock: drive inputs at the falling edge, model the rising edge, sample at the next falling edge.
  task automatic cycle(input logic r, input logic rdy, input logic rd,
                       input logic [AW-1:0] ra, input logic hq);
    rst = r; inst_ready = rdy; redirect = rd; redirect_addr = ra; halt_req = hq;
    @(posedge clk);
    model_step(r, rdy, rd, ra, hq);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to_pc(input logic [AW-1:0] pc, input string tag);
    for (int i = 0; i < 40 && !(m_valid && m_pc == pc); i++) cycle(0, 1, 0, '0, 0);
    check(tag, {23'd0, inst_valid, inst_pc}, {23'd0, 1'b1, pc});
  endtask

  initial begin
    logic [AW-1:0] wrap_seq [4];
    wrap_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_addr = '0; halt_req = 1'b0;
    @(negedge clk);

    // Reset state.
    cycle(1, 0, 0, '0, 0);
    cycle(1, 1, 1, 8'h33, 1);

    // Streaming from reset: valid two cycles after release.
    cycle(0, 1, 0, '0, 0);
    check("rst_bubble", 32'(inst_valid), 32'd0);
    cycle(0, 1, 0, '0, 0);
    check("first_inst", {inst_valid, inst_pc, inst}, {1'b1, 8'h00, 16'h1000});
    cycle(0, 1, 0, '0, 0);
    check("second_inst", {inst_valid, inst_pc, inst}, {1'b1, 8'h01, 16'h1001});
    run_to_pc(8'h05, "reach_pc5");

    // Three stall cycles at pc 5.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 0);
    check("stall_hold", {imem_addr, inst_pc, inst}, {8'h07, 8'h05, 16'h1005});
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt3", 32'(stall_count), 32'd3);
`else
    check("stall_cnt0", 32'(stall_count), 32'd0);
`endif
    cycle(0, 1, 0, '0, 0);
    check("after_stall", {inst_valid, inst_pc, inst}, {1'b1, 8'h06, 16'h1006});

    // Redirect at pc 3 with a simultaneous transfer.
    cycle(0, 1, 1, 8'h00, 0);
    run_to_pc(8'h03, "reach_pc3");
    cycle(0, 1, 1, 8'h40, 0);
    cycle(0, 1, 0, '0, 0);
    check("redir_bubble", 32'(inst_valid), 32'd0);
    cycle(0, 1, 0, '0, 0);
    check("redir_t0", {inst_valid, inst_pc, inst}, {1'b1, 8'h40, 16'h1040});
    cycle(0, 1, 0, '0, 0);
    check("redir_t1", {inst_valid, inst_pc, inst}, {1'b1, 8'h41, 16'h1041});

    // Address wrap.
    cycle(0, 1, 1, 8'hFE, 0);
    cycle(0, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, '0, 0);
      check("wrap_seq", {inst_valid, inst_pc}, {1'b1, wrap_seq[i]});
    end

    // Random traffic: backpressure, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), AW'($urandom), 1'b0);
    end

    // Halt together with redirect: halt wins and is sticky.
    cycle(0, 1, 1, 8'h00, 0);
    run_to_pc(8'h07, "reach_pc7");
    cycle(0, 1, 1, 8'h20, 1);
    check("halt_enter", {halted, inst_valid}, {1'b1, 1'b0});
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1'($urandom), 1'b1, AW'($urandom), 1'($urandom));
    end
    check("halt_sticky", {halted, inst_valid, imem_addr}, {1'b1, 1'b0, 8'h09});

    // Reset leaves HALT and restarts at 0.
    cycle(1, 1, 0, '0, 0);
    check("halt_rst", {halted, inst_valid, imem_addr}, {1'b0, 1'b0, 8'h00});
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    check("restart", {inst_valid, inst_pc, inst}, {1'b1, 8'h00, 16'h1000});

    // Reset in the middle of a stall.
    cycle(0, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    check("stall_rst", {inst_valid, stall_count}, {1'b0, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
